// File: rtl/branch_redirect_ctrl.sv
// PC redirect arbiter: Execute beats Decode, a redirect seen during a front-end stall is held
// and applied on the first unstalled cycle; saturating per-source counters for perf debug.
module branch_redirect_ctrl #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ex_redirect,
    input  logic [XLEN-1:0]      ex_target,
    input  logic                 dec_redirect,
    input  logic [XLEN-1:0]      dec_target,
    input  logic                 pc_stall,
    output logic                 pc_sel,
    output logic [XLEN-1:0]      pc_target,
    output logic                 flush_fd,
    output logic                 flush_dx,
    output logic                 redirect_pending,
    output logic [CNT_WIDTH-1:0] cnt_ex,
    output logic [CNT_WIDTH-1:0] cnt_dec
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
    typedef enum logic {SRC_DEC = 1'b0, SRC_EX = 1'b1} src_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state_q;
    src_t                  pend_src_q;
    logic [XLEN-1:0]       pend_target_q;
    logic [CNT_WIDTH-1:0]  cnt_ex_q, cnt_ex_d;
    logic [CNT_WIDTH-1:0]  cnt_dec_q, cnt_dec_d;
    logic                  inc_ex, inc_dec;

    // Redirects are visible in the same cycle; only the held entry and counters are state.
    always_comb begin
        pc_sel    = 1'b0;
        pc_target = '0;
        flush_fd  = 1'b0;
        flush_dx  = 1'b0;
        inc_ex    = 1'b0;
        inc_dec   = 1'b0;
        if (!pc_stall) begin
            if (state_q == PENDING) begin
                pc_sel    = 1'b1;
                pc_target = pend_target_q;
                flush_fd  = 1'b1;
                flush_dx  = (pend_src_q == SRC_EX);
                inc_ex    = (pend_src_q == SRC_EX);
                inc_dec   = (pend_src_q == SRC_DEC);
            end else if (ex_redirect) begin
                pc_sel    = 1'b1;
                pc_target = ex_target;
                flush_fd  = 1'b1;
                flush_dx  = 1'b1;
                inc_ex    = 1'b1;
            end else if (dec_redirect) begin
                pc_sel    = 1'b1;
                pc_target = dec_target;
                flush_fd  = 1'b1;
                inc_dec   = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_ex_d  = cnt_ex_q;
        cnt_dec_d = cnt_dec_q;
        if (inc_ex && cnt_ex_q != CNT_MAX)
            cnt_ex_d = cnt_ex_q + 1'b1;
        if (inc_dec && cnt_dec_q != CNT_MAX)
            cnt_dec_d = cnt_dec_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            pend_src_q    <= SRC_DEC;
            pend_target_q <= '0;
            cnt_ex_q      <= '0;
            cnt_dec_q     <= '0;
        end else begin
            cnt_ex_q  <= cnt_ex_d;
            cnt_dec_q <= cnt_dec_d;
            case (state_q)
                IDLE: begin
                    if (pc_stall && (ex_redirect || dec_redirect)) begin
                        state_q       <= PENDING;
                        pend_src_q    <= ex_redirect ? SRC_EX : SRC_DEC;
                        pend_target_q <= ex_redirect ? ex_target : dec_target;
                    end
                end
                PENDING: begin
                    if (!pc_stall) begin
                        state_q <= IDLE;
                    end else if (pend_src_q == SRC_DEC && ex_redirect) begin
                        // An older Execute redirect supersedes a held Decode jump.
                        pend_src_q    <= SRC_EX;
                        pend_target_q <= ex_target;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_pending = (state_q == PENDING);
    assign cnt_ex           = cnt_ex_q;
    assign cnt_dec          = cnt_dec_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with 4-bit counters so saturation is reachable.
module tb_branch_redirect_ctrl;

    logic        clock;
    logic        reset;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        dec_redirect;
    logic [31:0] dec_target;
    logic        pc_stall;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        flush_fd;
    logic        flush_dx;
    logic        redirect_pending;
    logic [3:0]  cnt_ex;
    logic [3:0]  cnt_dec;

    int total = 0;
    int bad   = 0;

    branch_redirect_ctrl #(.XLEN(32), .CNT_WIDTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .ex_redirect     (ex_redirect),
        .ex_target       (ex_target),
        .dec_redirect    (dec_redirect),
        .dec_target      (dec_target),
        .pc_stall        (pc_stall),
        .pc_sel          (pc_sel),
        .pc_target       (pc_target),
        .flush_fd        (flush_fd),
        .flush_dx        (flush_dx),
        .redirect_pending(redirect_pending),
        .cnt_ex          (cnt_ex),
        .cnt_dec         (cnt_dec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge so combinational checks sit mid-cycle.
    task automatic drive(input logic ex, input logic [31:0] et, input logic dec,
                         input logic [31:0] dt, input logic stall);
        @(negedge clock);
        ex_redirect  = ex;
        ex_target    = et;
        dec_redirect = dec;
        dec_target   = dt;
        pc_stall     = stall;
        #1;
    endtask

    task automatic comb(input string tag, input logic sel, input logic [31:0] tgt,
                        input logic fd, input logic dx);
        chk({tag, "_sel"}, {31'd0, pc_sel}, {31'd0, sel});
        chk({tag, "_tgt"}, pc_target, tgt);
        chk({tag, "_fd"}, {31'd0, flush_fd}, {31'd0, fd});
        chk({tag, "_dx"}, {31'd0, flush_dx}, {31'd0, dx});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        ex_redirect = 1'b0; ex_target = '0;
        dec_redirect = 1'b0; dec_target = '0;
        pc_stall = 1'b0;
        tick(); tick();
        drive(0, 32'h0, 0, 32'h0, 0);
        reset = 1'b1;
        #1;
        comb("rst", 0, 32'h0, 0, 0);
        chk("rst_pend", {31'd0, redirect_pending}, 32'd0);
        chk("rst_cex", {28'd0, cnt_ex}, 32'd0);
        chk("rst_cdec", {28'd0, cnt_dec}, 32'd0);

        // Unstalled Execute redirect
        drive(1, 32'h40, 0, 32'h0, 0);
        comb("ex", 1, 32'h40, 1, 1);
        tick();
        chk("ex_cex", {28'd0, cnt_ex}, 32'd1);
        chk("ex_pend", {31'd0, redirect_pending}, 32'd0);

        // Both sources: Execute wins, Decode not counted
        drive(1, 32'h80, 1, 32'h10, 0);
        comb("both", 1, 32'h80, 1, 1);
        tick();
        chk("both_cex", {28'd0, cnt_ex}, 32'd2);
        chk("both_cdec", {28'd0, cnt_dec}, 32'd0);

        drive(0, 32'h0, 0, 32'h0, 0);
        comb("none", 0, 32'h0, 0, 0);
        tick();

        // Decode only, unstalled
        drive(0, 32'h0, 1, 32'h14, 0);
        comb("dec", 1, 32'h14, 1, 0);
        tick();
        chk("dec_cdec", {28'd0, cnt_dec}, 32'd1);

        // Decode jump held across a 3-cycle stall
        drive(0, 32'h0, 1, 32'h22, 1);
        comb("hold0", 0, 32'h0, 0, 0);
        chk("hold0_pend", {31'd0, redirect_pending}, 32'd0);
        tick();
        chk("hold1_pend", {31'd0, redirect_pending}, 32'd1);
        drive(0, 32'h0, 1, 32'h22, 1);
        comb("hold1", 0, 32'h0, 0, 0);
        tick();
        chk("hold2_pend", {31'd0, redirect_pending}, 32'd1);
        drive(0, 32'h0, 1, 32'h22, 1);
        comb("hold2", 0, 32'h0, 0, 0);
        tick();
        chk("hold3_pend", {31'd0, redirect_pending}, 32'd1);
        drive(1, 32'h99, 1, 32'h77, 0);
        comb("rel", 1, 32'h22, 1, 0);
        tick();
        chk("rel_pend", {31'd0, redirect_pending}, 32'd0);
        chk("rel_cdec", {28'd0, cnt_dec}, 32'd2);
        chk("rel_cex", {28'd0, cnt_ex}, 32'd2);

        // Held Decode upgraded by Execute during the stall
        drive(0, 32'h0, 1, 32'h22, 1);
        tick();
        drive(1, 32'h55, 0, 32'h0, 1);
        comb("upg_hold", 0, 32'h0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0);
        comb("upg", 1, 32'h55, 1, 1);
        tick();
        chk("upg_cex", {28'd0, cnt_ex}, 32'd3);
        chk("upg_cdec", {28'd0, cnt_dec}, 32'd2);

        // Held Execute entry is not replaced by a later Execute redirect
        drive(1, 32'h60, 0, 32'h0, 1);
        tick();
        drive(1, 32'h70, 0, 32'h0, 1);
        tick();
        drive(0, 32'h0, 0, 32'h0, 0);
        comb("keep", 1, 32'h60, 1, 1);
        tick();
        chk("keep_cex", {28'd0, cnt_ex}, 32'd4);

        // Reset while pending discards the held redirect and clears counters
        drive(0, 32'h0, 1, 32'h30, 1);
        tick();
        chk("rp_pend", {31'd0, redirect_pending}, 32'd1);
        drive(0, 32'h0, 0, 32'h0, 1);
        reset = 1'b0;
        tick();
        chk("rp_pend0", {31'd0, redirect_pending}, 32'd0);
        drive(0, 32'h0, 0, 32'h0, 0);
        reset = 1'b1;
        #1;
        comb("rp_rel", 0, 32'h0, 0, 0);
        tick();
        chk("rp_cex", {28'd0, cnt_ex}, 32'd0);
        chk("rp_cdec", {28'd0, cnt_dec}, 32'd0);

        // Saturation of the 4-bit Execute counter
        for (int i = 1; i <= 17; i++) begin
            drive(1, 32'h100 + i, 0, 32'h0, 0);
            tick();
            chk($sformatf("sat%0d", i), {28'd0, cnt_ex}, (i > 15) ? 32'd15 : i);
        end
        chk("sat_cdec", {28'd0, cnt_dec}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences PC redirection and pipeline squashing for the 5-stage core. Arbitrates between two redirect sources: early-resolved J/JAL in Decode, and late-resolved BNE/BLT/BEX/JR in Execute, driven by the Execute-stage branch unit's taken/target outputs. Holds a redirect that arrives while the front end is stalled and applies it on the first unstalled cycle. Keeps saturating per-source redirect counters for performance debug.

Parameters:
XLEN, 32, PC/target width
CNT_WIDTH, 16, width of each saturating redirect counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; sampled on the rising clock edge
ex_redirect  in  1  Execute-stage branch/jump taken (BNE, BLT, BEX, JR)
ex_target  in  XLEN  Execute-stage redirect target
dec_redirect  in  1  Decode-stage J/JAL detected
dec_target  in  XLEN  Decode-stage jump target (sign-extended T)
pc_stall  in  1  PC and F/D latch hold this cycle (multdiv or load-use)
pc_sel  out  1  1 = PC latch loads pc_target instead of PC+1
pc_target  out  XLEN  selected redirect target
flush_fd  out  1  insert nop into F/D latch this cycle
flush_dx  out  1  insert nop into D/X latch this cycle
redirect_pending  out  1  a redirect is held awaiting stall release
cnt_ex  out  CNT_WIDTH  Execute redirects applied, saturating
cnt_dec  out  CNT_WIDTH  Decode redirects applied, saturating

Behaviour:
- States: IDLE, PENDING. Registers: state, pend_src (EX/DEC), pend_target, cnt_ex, cnt_dec.
- Reset (reset==0 at a rising edge): state=IDLE, pend_src=DEC, pend_target=0, cnt_ex=0, cnt_dec=0. Any held redirect is discarded. Combinational outputs evaluate to 0 while in IDLE with all inputs low.
- Arbitration: Execute wins over Decode because it is the older instruction. If both sources are asserted, the Decode jump is squashed and is not counted.
- IDLE, pc_stall=0:
  - Execute wins: pc_sel=1, pc_target=ex_target, flush_fd=1, flush_dx=1, cnt_ex++.
  - Decode only: pc_sel=1, pc_target=dec_target, flush_fd=1, flush_dx=0, cnt_dec++.
  - Neither: all outputs 0.
  - Latency is 0 cycles (combinational from the inputs). State stays IDLE.
- IDLE, pc_stall=1, any redirect asserted:
  - Capture the winning source's target and src into pend_*. Go to PENDING.
  - pc_sel, flush_fd and flush_dx stay 0 this cycle. No count.
- PENDING, pc_stall=1:
  - Hold. redirect_pending=1. Other outputs 0.
  - Upgrade rule: if pend_src=DEC and ex_redirect=1, replace the pending entry with the EX entry.
  - Otherwise new inputs are ignored (the frozen pipeline re-presents the same instruction).
- PENDING, pc_stall=0:
  - Apply the pending entry: pc_sel=1, pc_target=pend_target, flush_fd=1, flush_dx=(pend_src==EX).
  - Increment the counter matching pend_src. Go to IDLE.
  - ex_redirect and dec_redirect are ignored this cycle; they belong to the instruction being retired by the flush.
- redirect_pending equals (state==PENDING), registered.
- Counters: increment by 1 per applied redirect. They saturate at 2^CNT_WIDTH-1 and never wrap.
- Upstream guarantees (not checked by this block):
  - J/JAL never raise ex_redirect.
  - The target inputs are stable whenever their strobe is high.
- Reset asserted while in PENDING: return to IDLE next edge. No pc_sel is issued and no counter changes.

Test Plan:
- ex_redirect=1, ex_target=0x40, pc_stall=0 in IDLE -> same cycle pc_sel=1, pc_target=0x40, flush_fd=flush_dx=1; cnt_ex=1 after edge.
- dec_redirect=1 (target 0x10) and ex_redirect=1 (target 0x80) same cycle -> pc_target=0x80, flush_dx=1; cnt_ex=1, cnt_dec=0.
- dec_redirect=1, target 0x22, pc_stall=1 for 3 cycles, then 0 -> redirect_pending=1 for those 3 cycles with pc_sel=0; on release cycle pc_sel=1, pc_target=0x22, flush_fd=1, flush_dx=0; redirect_pending=0 after; cnt_dec=1.
- PENDING with DEC 0x22, then ex_redirect=1 target 0x55 during the stall -> on release pc_target=0x55, flush_dx=1, cnt_ex=1, cnt_dec=0.
- Enter PENDING, then drive reset=0 for one edge while pc_stall=1 -> state IDLE, redirect_pending=0, no pc_sel on later release, counters 0.
- CNT_WIDTH=4, 17 unstalled EX redirects -> cnt_ex reaches 15 and holds at 15.
